// File: rtl/dw_update_ctrl_if.sv
// Upstream delta-weight handshake: one 16-bit signed Q6.10 sample per
// accepted beat (dw_valid & dw_ready).
interface dw_update_ctrl_if;
  logic        dw_valid;
  logic        dw_ready;
  logic [15:0] dw_in;

  // Upstream delta pipeline side
  modport master (output dw_valid, output dw_in, input dw_ready);
  // Update controller side
  modport slave  (input dw_valid, input dw_in, output dw_ready);
endinterface

// File: rtl/dw_update_ctrl.sv
// Weight-update sequencer for the 4-sample delta-weight adder.
// Per weight: collect 4 dw samples, replay them into the adder on 4
// consecutive cycles, then add the adder's eta*sum result into the weight
// register file with 16-bit saturation. One start walks all NW weights.
module dw_update_ctrl #(
  parameter int NW  = 4,
  parameter int IW  = 2,
  parameter int LAT = 1
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic            start,
  dw_update_ctrl_if.slave dw_bus,
  output logic [15:0]     adder_dw,
  input  logic [15:0]     adder_dcdw3,
  input  logic            w_ld,
  input  logic [IW-1:0]   w_ld_idx,
  input  logic [15:0]     w_ld_data,
  input  logic [IW-1:0]   rd_idx,
  output logic [15:0]     rd_data,
  output logic            busy,
  output logic            done,
  output logic            sat_flag
);

  typedef enum logic [2:0] {IDLE, FILL, BURST, WAIT, WRITE} state_t;

  localparam int WCW = (LAT > 2) ? $clog2(LAT) : 1;

  state_t          state_reg, state_next;
  logic [2:0]      cnt_reg;
  logic [1:0]      bcnt_reg;
  logic [WCW-1:0]  wcnt_reg;
  logic [IW-1:0]   idx_reg;
  logic [15:0]     smp_reg [4];
  logic            done_reg;
  logic            sat_reg;
  logic [15:0]     w_arr [NW];

  logic            accept;
  logic            last_idx;
  logic [16:0]     wr_sum;
  logic            wr_sat;
  logic [15:0]     wr_val;

  assign dw_bus.dw_ready = (state_reg == FILL) && (cnt_reg < 3'd4);
  assign accept          = dw_bus.dw_ready && dw_bus.dw_valid;
  assign last_idx        = (idx_reg == IW'(NW - 1));

  // 17-bit signed sum catches any overflow; clamp to the 16-bit extremes
  assign wr_sum = {w_arr[idx_reg][15], w_arr[idx_reg]} + {adder_dcdw3[15], adder_dcdw3};
  assign wr_sat = wr_sum[16] ^ wr_sum[15];
  assign wr_val = wr_sat ? (wr_sum[16] ? 16'h8000 : 16'h7FFF) : wr_sum[15:0];

  // Adder sees buffered samples only during the burst, zero otherwise
  assign adder_dw = (state_reg == BURST) ? smp_reg[bcnt_reg] : 16'd0;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign sat_flag = sat_reg;
  assign rd_data  = (int'(rd_idx) < NW) ? w_arr[rd_idx] : 16'd0;

  // State register
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = FILL;
      FILL:  if (accept && cnt_reg == 3'd3) state_next = BURST;
      BURST: if (bcnt_reg == 2'd3) state_next = (LAT == 1) ? WRITE : WAIT;
      WAIT:  if (wcnt_reg == WCW'(LAT - 2)) state_next = WRITE;
      WRITE: state_next = last_idx ? IDLE : FILL;
      default: state_next = IDLE;
    endcase
  end

  // Sample buffer, counters, weight index and pass status flags
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt_reg  <= '0;
      bcnt_reg <= '0;
      wcnt_reg <= '0;
      idx_reg  <= '0;
      done_reg <= 1'b0;
      sat_reg  <= 1'b0;
      for (int i = 0; i < 4; i++) smp_reg[i] <= '0;
    end else begin
      done_reg <= (state_reg == WRITE) && last_idx;
      case (state_reg)
        IDLE: begin
          if (start) begin
            idx_reg <= '0;
            cnt_reg <= '0;
            sat_reg <= 1'b0;
          end
        end
        FILL: begin
          bcnt_reg <= '0;
          if (accept) begin
            smp_reg[cnt_reg[1:0]] <= dw_bus.dw_in;
            cnt_reg               <= cnt_reg + 3'd1;
          end
        end
        BURST: begin
          bcnt_reg <= bcnt_reg + 2'd1;
          wcnt_reg <= '0;
        end
        WAIT: begin
          wcnt_reg <= wcnt_reg + WCW'(1);
        end
        WRITE: begin
          cnt_reg <= '0;
          if (wr_sat) sat_reg <= 1'b1;
          idx_reg <= last_idx ? '0 : idx_reg + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Weight register file: one register per entry, written by the update
  // pass or, while idle, by an external load
  generate
    for (genvar gi = 0; gi < NW; gi++) begin : g_w
      logic [15:0] w_reg;
      // Entry gi update
      always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)
          w_reg <= '0;
        else if (state_reg == WRITE && idx_reg == IW'(gi))
          w_reg <= wr_val;
        else if (state_reg == IDLE && w_ld && w_ld_idx == IW'(gi))
          w_reg <= w_ld_data;
      end
      assign w_arr[gi] = w_reg;
    end
  endgenerate

endmodule

// File: tb/tb_dw_update_ctrl.sv
// Randomised bench for dw_update_ctrl with a behavioural dw_adder (LAT=1).
// The stimulus side pushes expected adder beats and weight-write records;
// a negedge monitor pops and compares them as the DUT presents them.
module tb_dw_update_ctrl;
  localparam int NW  = 4;
  localparam int IW  = 2;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          res_n;
  logic          start;
  logic [15:0]   adder_dw;
  logic [15:0]   adder_dcdw3;
  logic          w_ld;
  logic [IW-1:0] w_ld_idx;
  logic [15:0]   w_ld_data;
  logic [IW-1:0] rd_idx;
  logic [15:0]   rd_data;
  logic          busy, done, sat_flag;

  dw_update_ctrl_if dwi();

  dw_update_ctrl #(.NW(NW), .IW(IW), .LAT(LAT)) dut (
    .clk(clk), .res_n(res_n), .start(start), .dw_bus(dwi),
    .adder_dw(adder_dw), .adder_dcdw3(adder_dcdw3),
    .w_ld(w_ld), .w_ld_idx(w_ld_idx), .w_ld_data(w_ld_data),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  // Behavioural dw_adder: eta = -103/1024, sum of the last 4 dw, 1-cycle latency
  logic [15:0] win0, win1, win2;
  wire signed [31:0] adder_sum = 32'($signed(win0)) + 32'($signed(win1))
                               + 32'($signed(win2)) + 32'($signed(adder_dw));
  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      win0 <= '0; win1 <= '0; win2 <= '0; adder_dcdw3 <= '0;
    end else begin
      adder_dcdw3 <= 16'((adder_sum * -32'sd103) >>> 10);
      win2 <= win1; win1 <= win0; win0 <= adder_dw;
    end
  end

  typedef struct {
    logic [15:0] old_w;
    logic [15:0] new_w;
    bit          last;
    bit          sat;
  } wr_rec_t;

  logic [15:0] exp_adw [$];
  wr_rec_t     exp_wr  [$];
  logic [15:0] w_model [NW];
  bit          sat_pass;
  int          vectors = 0;
  int          miscompares = 0;
  int          passes_expected = 0;
  int          done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Monitor: reset outputs, burst beats, write cycle and post-write readback
  initial begin
    int beats = 0;
    int ph = 0;
    wr_rec_t rec;
    forever begin
      @(negedge clk);
      if (!res_n) begin
        check("rst_dw_ready", dwi.dw_ready, 0);
        check("rst_adder_dw", adder_dw, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_rd_data", rd_data, 0);
        beats = 0; ph = 0;
        exp_adw.delete(); exp_wr.delete();
        continue;
      end
      if (done) done_seen++;
      if (ph == 0) begin
        if (dwi.dw_valid && dwi.dw_ready) begin
          beats++;
          if (beats == 4) begin beats = 0; ph = 1; end
        end
      end else if (ph <= 4) begin
        if (ph == 1) check("ready_after_4th", dwi.dw_ready, 0);
        if (exp_adw.size() == 0) check("adw_queue_empty", 1, 0);
        else check("burst_adder_dw", adder_dw, exp_adw.pop_front());
        ph++;
      end else if (ph < 4 + LAT) begin
        ph++;
      end else if (ph == 4 + LAT) begin
        if (exp_wr.size() == 0) check("wr_queue_empty", 1, 0);
        else begin
          rec = exp_wr[0];
          check("write_cycle_old_w", rd_data, rec.old_w);
        end
        check("write_cycle_adder_dw", adder_dw, 0);
        ph++;
      end else begin
        if (exp_wr.size() != 0) begin
          rec = exp_wr.pop_front();
          check("new_w", rd_data, rec.new_w);
          check("done_pulse", done, rec.last);
          check("busy_after_write", busy, !rec.last);
          check("sat_flag", sat_flag, rec.sat);
        end
        ph = 0;
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    sat_pass = 0;
  endtask

  task automatic load(input int k, input logic [15:0] d);
    w_ld = 1'b1; w_ld_idx = IW'(k); w_ld_data = d;
    tick();
    w_ld = 1'b0;
    w_model[k] = d;
  endtask

  // abort: 0 none, 1 reset during burst, 2 start/w_ld pulsed during burst
  task automatic do_weight(input int k, input logic [15:0] s [4], input int vmode, input int abort);
    int sum, prod, d, nw, n, cyc, pi;
    bit v, sat;
    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      sum += int'($signed(s[i]));
      exp_adw.push_back(s[i]);
    end
    prod = -103 * sum;
    d = prod / 1024;
    if (prod < 0 && (prod % 1024) != 0) d = d - 1;
    nw = int'($signed(w_model[k])) + d;
    sat = 0;
    if (nw > 32767)  begin nw = 32767;  sat = 1; end
    if (nw < -32768) begin nw = -32768; sat = 1; end
    sat_pass = sat_pass | sat;
    exp_wr.push_back('{old_w: w_model[k], new_w: 16'(nw), last: (k == NW - 1), sat: sat_pass});
    w_model[k] = 16'(nw);
    rd_idx = IW'(k);
    n = 0; cyc = 0; pi = 0;
    while (n < 4 && cyc < 200) begin
      if (vmode == 0) v = 1;
      else if (vmode == 1) v = ($urandom_range(0, 1) == 1);
      else v = (pi < 7) ? pat[pi] : 1'b1;
      pi++;
      dwi.dw_valid = v;
      dwi.dw_in = v ? s[n] : 16'($urandom);
      @(negedge clk);
      if (dwi.dw_valid && dwi.dw_ready) n++;
      tick();
      cyc++;
    end
    dwi.dw_valid = 1'b0;
    if (n < 4) check("fill_timeout", n, 4);
    if (abort == 1) begin
      tick();
      res_n = 1'b0;
      tick();
      res_n = 1'b1;
      for (int i = 0; i < NW; i++) w_model[i] = '0;
    end else if (abort == 2) begin
      start = 1'b1; w_ld = 1'b1; w_ld_idx = IW'(k); w_ld_data = 16'h1234;
      tick();
      start = 1'b0; w_ld = 1'b0;
      repeat (4 + LAT) tick();
    end else begin
      repeat (5 + LAT) tick();
    end
  endtask

  // smode: 0 all 1.0, 1 full-range random, 2 small random, 3 idx2 = 0x7FFF
  task automatic run_pass(input int smode, input int vmode, input int abort_k, input int abort_type);
    logic [15:0] s [4];
    int ab;
    do_start();
    for (int k = 0; k < NW; k++) begin
      for (int i = 0; i < 4; i++) begin
        case (smode)
          0: s[i] = 16'h0400;
          1: s[i] = 16'($urandom);
          3: s[i] = (k == 2) ? 16'h7FFF : 16'($urandom_range(0, 2047) - 1024);
          default: s[i] = 16'($urandom_range(0, 2047) - 1024);
        endcase
      end
      ab = (k == abort_k) ? abort_type : 0;
      do_weight(k, s, vmode, ab);
      if (ab == 1) return;
    end
    passes_expected++;
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NW; k++) begin
      rd_idx = IW'(k);
      @(negedge clk);
      check(tag, rd_data, w_model[k]);
      tick();
    end
  endtask

  task automatic check_const(input string tag, input int k, input logic [15:0] v);
    rd_idx = IW'(k);
    @(negedge clk);
    check(tag, rd_data, v);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_n = 1'b0; start = 1'b0; w_ld = 1'b0; w_ld_idx = '0; w_ld_data = '0;
    rd_idx = '0; dwi.dw_valid = 1'b0; dwi.dw_in = '0;
    for (int i = 0; i < NW; i++) w_model[i] = '0;
    repeat (3) tick();
    res_n = 1'b1;
    tick();

    // Single update / full pass with dw = 1.0
    run_pass(0, 0, -1, 0);
    for (int k = 0; k < NW; k++) check_const("w_fe64", k, 16'hFE64);

    // Idle loads, then backpressured pass with the 1,0,0,1,1,0,1 pattern
    for (int k = 0; k < NW; k++) load(k, 16'($urandom_range(0, 4095) - 2048));
    check_all("w_ld_readback");
    run_pass(2, 2, -1, 0);
    check_all("backpressure_w");

    // Random passes with random valid gaps
    repeat (3) begin
      run_pass(1, 1, -1, 0);
      check_all("random_w");
    end

    // Saturation on idx 2, then sat_flag must clear at the next start
    load(2, 16'h8010);
    run_pass(3, 0, -1, 0);
    check_const("w2_sat", 2, 16'h8000);
    check("sat_sticky_idle", sat_flag, 1);
    run_pass(2, 0, -1, 0);
    check_all("post_sat_w");

    // start and w_ld pulsed during the burst of idx 1
    run_pass(2, 1, 1, 2);
    check_all("ignored_ctrl_w");

    // Reset during the burst of idx 1, then a clean pass
    for (int k = 0; k < NW; k++) load(k, 16'($urandom));
    run_pass(2, 0, 1, 1);
    tick();
    check_all("after_reset_w");
    run_pass(0, 0, -1, 0);
    for (int k = 0; k < NW; k++) check_const("w_fe64_after_reset", k, 16'hFE64);

    repeat (3) tick();
    check("done_count", done_seen, passes_expected);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
